// File: rtl/parking_gate_counter.sv
// Multi-gate parking occupancy counter: per-gate sensor-pair FSMs feeding a shared
// saturating occupancy register. Optional input debounce is enabled by PGC_DEBOUNCE_EN.
module parking_gate_counter #(
  parameter int  NUM_GATES  = 2,
  parameter int  CAPACITY   = 15,
  parameter int  DEB_CYCLES = 4,
  localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_GATES-1:0]   sens_a,
  input  logic [NUM_GATES-1:0]   sens_b,
  input  logic                   occ_load,
  input  logic [CNT_W-1:0]       occ_load_val,
  input  logic                   err_clr,
  output logic [NUM_GATES-1:0]   car_enter,
  output logic [NUM_GATES-1:0]   car_exit,
  output logic [CNT_W-1:0]       occupancy,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_err,
  output logic                   unf_err,
  output logic [4*NUM_GATES-1:0] dbg_state
);

  localparam int PCW = $clog2(NUM_GATES + 1);
  localparam int SW  = CNT_W + PCW + 1;

  if (NUM_GATES < 1 || NUM_GATES > 8) begin : g_bad_gates
    $error("NUM_GATES out of range");
  end
  if (CAPACITY < 1 || CAPACITY > 65535) begin : g_bad_cap
    $error("CAPACITY out of range");
  end
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("DEB_CYCLES out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_EN1     = 4'd1,
    S_EN2     = 4'd2,
    S_EN3     = 4'd3,
    S_EN_DONE = 4'd4,
    S_EX1     = 4'd5,
    S_EX2     = 4'd6,
    S_EX3     = 4'd7,
    S_EX_DONE = 4'd8
  } gate_state_e;

  // Two-flop synchronizers for the asynchronous sensor inputs.
  logic [NUM_GATES-1:0] a_meta_q, a_sync_q, b_meta_q, b_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_meta_q <= '0;
      a_sync_q <= '0;
      b_meta_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_meta_q <= sens_a;
      a_sync_q <= a_meta_q;
      b_meta_q <= sens_b;
      b_sync_q <= b_meta_q;
    end
  end

  logic [NUM_GATES-1:0] enter_w, exit_w;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    logic [1:0]  sym_sync, sym_fsm;
    gate_state_e state_q, state_d;
    logic        en_pulse, ex_pulse;

    assign sym_sync = {a_sync_q[g], b_sync_q[g]};

`ifdef PGC_DEBOUNCE_EN
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    logic [1:0]     cand_q, acc_q;
    logic [DCW-1:0] run_q, run_d;

    // run_d counts consecutive cycles (including this one) the symbol has been stable.
    always_comb begin
      run_d = run_q;
      if (sym_sync != cand_q) begin
        run_d = DCW'(1);
      end else if (run_q < DCW'(DEB_CYCLES)) begin
        run_d = run_q + DCW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cand_q <= '0;
        acc_q  <= '0;
        run_q  <= '0;
      end else begin
        cand_q <= sym_sync;
        run_q  <= run_d;
        if (run_d == DCW'(DEB_CYCLES)) begin
          acc_q <= sym_sync;
        end
      end
    end

    assign sym_fsm = acc_q;
`else
    assign sym_fsm = sym_sync;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE: begin
          if (sym_fsm == 2'b10)      state_d = S_EN1;
          else if (sym_fsm == 2'b01) state_d = S_EX1;
        end
        S_EN1: begin
          if (sym_fsm == 2'b00)      state_d = S_IDLE;
          else if (sym_fsm == 2'b11) state_d = S_EN2;
        end
        S_EN2: begin
          if (sym_fsm == 2'b01)      state_d = S_EN3;
          else if (sym_fsm == 2'b10) state_d = S_EN1;
        end
        S_EN3: begin
          if (sym_fsm == 2'b00)      state_d = S_EN_DONE;
          else if (sym_fsm == 2'b11) state_d = S_EN2;
        end
        S_EN_DONE: state_d = S_IDLE;
        S_EX1: begin
          if (sym_fsm == 2'b00)      state_d = S_IDLE;
          else if (sym_fsm == 2'b11) state_d = S_EX2;
        end
        S_EX2: begin
          if (sym_fsm == 2'b10)      state_d = S_EX3;
          else if (sym_fsm == 2'b01) state_d = S_EX1;
        end
        S_EX3: begin
          if (sym_fsm == 2'b00)      state_d = S_EX_DONE;
          else if (sym_fsm == 2'b11) state_d = S_EX2;
        end
        S_EX_DONE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    always_comb begin
      en_pulse = (state_q == S_EN_DONE);
      ex_pulse = (state_q == S_EX_DONE);
    end

    assign enter_w[g]             = en_pulse;
    assign exit_w[g]              = ex_pulse;
    assign dbg_state[4*g +: 4]    = state_q;
  end

  assign car_enter = enter_w;
  assign car_exit  = exit_w;

  logic [CNT_W-1:0]     occ_q, occ_d, load_clamped;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic [PCW-1:0]       n_en, n_ex;
  logic signed [SW-1:0] nxt;

  // Signed net change is wide enough that both overflow and underflow stay representable.
  always_comb begin
    n_en = '0;
    n_ex = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      n_en = n_en + PCW'(enter_w[i]);
      n_ex = n_ex + PCW'(exit_w[i]);
    end
    nxt = $signed(SW'(occ_q)) + $signed(SW'(n_en)) - $signed(SW'(n_ex));
    load_clamped = (occ_load_val > CNT_W'(CAPACITY)) ? CNT_W'(CAPACITY) : occ_load_val;
  end

  always_comb begin
    occ_d = occ_q;
    ovf_d = ovf_q & ~err_clr;
    unf_d = unf_q & ~err_clr;
    if (occ_load) begin
      occ_d = load_clamped;
    end else if (nxt > $signed(SW'(CAPACITY))) begin
      occ_d = CNT_W'(CAPACITY);
      ovf_d = 1'b1;
    end else if (nxt < 0) begin
      occ_d = '0;
      unf_d = 1'b1;
    end else begin
      occ_d = CNT_W'(nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == CNT_W'(CAPACITY));
  assign empty     = (occ_q == '0);
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule

// File: tb/tb_parking_gate_counter.sv
// Directed bench for parking_gate_counter with NUM_GATES=2, CAPACITY=3.
module tb_parking_gate_counter;

  localparam int NG    = 2;
  localparam int CAP   = 3;
  localparam int CW    = 2;
`ifdef PGC_DEBOUNCE_EN
  localparam int HOLD    = 6;
  localparam int LAT_EXP = 7;
`else
  localparam int HOLD    = 5;
  localparam int LAT_EXP = 3;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NG-1:0]   sens_a = '0, sens_b = '0;
  logic            occ_load = 1'b0;
  logic [CW-1:0]   occ_load_val = '0;
  logic            err_clr = 1'b0;
  logic [NG-1:0]   car_enter, car_exit;
  logic [CW-1:0]   occupancy;
  logic            full, empty, ovf_err, unf_err;
  logic [4*NG-1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  parking_gate_counter #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
    .clk(clk), .reset_n(reset_n), .sens_a(sens_a), .sens_b(sens_b),
    .occ_load(occ_load), .occ_load_val(occ_load_val), .err_clr(err_clr),
    .car_enter(car_enter), .car_exit(car_exit), .occupancy(occupancy),
    .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err),
    .dbg_state(dbg_state)
  );

  // pulse monitor, sampled on the falling edge
  int cyc_n = 0;
  int en_n[NG], ex_n[NG];
  int en0_cyc = 0, occ_at_en0 = -1, occ_after_en0 = -1;
  int empty_after_en0 = -1;
  logic en0_prev = 1'b0;
  logic g0_busy = 1'b0;

  initial begin
    for (int i = 0; i < NG; i++) begin
      en_n[i] = 0;
      ex_n[i] = 0;
    end
  end

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    for (int i = 0; i < NG; i++) begin
      if (car_enter[i]) en_n[i]++;
      if (car_exit[i])  ex_n[i]++;
    end
    if (en0_prev) begin
      occ_after_en0   = int'(occupancy);
      empty_after_en0 = int'(empty);
    end
    if (car_enter[0]) begin
      occ_at_en0 = int'(occupancy);
      en0_cyc    = cyc_n;
    end
    en0_prev = car_enter[0];
    if (dbg_state[3:0] != 4'd0) g0_busy = 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int last_sym_cyc = 0;

  // Each sequence packs five {a,b} symbols, first symbol in the top bits.
  task automatic run_seq2(input logic [9:0] seq0, input logic [9:0] seq1,
                          input logic use0, input logic use1);
    logic [1:0] s0, s1;
    for (int i = 0; i < 5; i++) begin
      s0 = seq0[9-2*i -: 2];
      s1 = seq1[9-2*i -: 2];
      if (use0) begin sens_a[0] = s0[1]; sens_b[0] = s0[0]; end
      if (use1) begin sens_a[1] = s1[1]; sens_b[1] = s1[0]; end
      if (i == 4) last_sym_cyc = cyc_n;
      cyc(HOLD);
    end
    cyc(12);
  endtask

  task automatic load_occ(input logic [CW-1:0] v);
    occ_load = 1'b1;
    occ_load_val = v;
    cyc(1);
    occ_load = 1'b0;
    cyc(1);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  localparam logic [9:0] ENTRY = 10'b00_10_11_01_00;
  localparam logic [9:0] EXIT  = 10'b00_01_11_10_00;
  localparam logic [9:0] ABORT = 10'b00_10_11_10_00;

  int e0, x1;

  initial begin
    cyc(3);
    check("rst_occ",   int'(occupancy), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full), 0);
    check("rst_ovf",   int'(ovf_err), 0);
    check("rst_unf",   int'(unf_err), 0);
    check("rst_pulse", int'({car_enter, car_exit}), 0);
    reset_n = 1'b1;
    cyc(3);

    // entry on gate 0
    run_seq2(ENTRY, 10'b0, 1'b1, 1'b0);
    check("ent_cnt",       en_n[0], 1);
    check("ent_occ_pulse", occ_at_en0, 0);
    check("ent_occ_next",  occ_after_en0, 1);
    check("ent_empty",     empty_after_en0, 0);
    check("ent_latency",   en0_cyc - last_sym_cyc, LAT_EXP);
    check("ent_occ",       int'(occupancy), 1);

    // exit on gate 1 from occupancy 2
    load_occ(2'd2);
    check("load2", int'(occupancy), 2);
    run_seq2(10'b0, EXIT, 1'b0, 1'b1);
    check("exit_cnt", ex_n[1], 1);
    check("exit_occ", int'(occupancy), 1);

    // aborted entry
    e0 = en_n[0];
    x1 = ex_n[1];
    run_seq2(ABORT, 10'b0, 1'b1, 1'b0);
    check("abort_en", en_n[0] - e0, 0);
    check("abort_ex", ex_n[0] + ex_n[1] - x1, 0);
    check("abort_occ", int'(occupancy), 1);

    // overflow while full
    load_occ(2'd3);
    check("full_flag", int'(full), 1);
    run_seq2(ENTRY, 10'b0, 1'b1, 1'b0);
    check("ovf_occ", int'(occupancy), 3);
    check("ovf_set", int'(ovf_err), 1);
    clear_err();
    check("ovf_clr", int'(ovf_err), 0);

    // simultaneous enter + exit while full nets out
    e0 = en_n[0];
    x1 = ex_n[1];
    run_seq2(ENTRY, EXIT, 1'b1, 1'b1);
    check("sim_en", en_n[0] - e0, 1);
    check("sim_ex", ex_n[1] - x1, 1);
    check("sim_occ", int'(occupancy), 3);
    check("sim_ovf", int'(ovf_err), 0);

    // underflow while empty
    load_occ(2'd0);
    run_seq2(10'b0, EXIT, 1'b0, 1'b1);
    check("unf_occ", int'(occupancy), 0);
    check("unf_set", int'(unf_err), 1);
    check("unf_ovf", int'(ovf_err), 0);
    clear_err();
    check("unf_clr", int'(unf_err), 0);

    // reset mid-sequence
    load_occ(2'd2);
    sens_a[0] = 1'b1; sens_b[0] = 1'b0;
    cyc(HOLD);
    sens_b[0] = 1'b1;
    cyc(HOLD);
    e0 = en_n[0];
    reset_n = 1'b0;
    cyc(2);
    check("mid_occ",   int'(occupancy), 0);
    check("mid_empty", int'(empty), 1);
    check("mid_state", int'(dbg_state), 0);
    reset_n = 1'b1;
    cyc(1);
    sens_a[0] = 1'b0;
    cyc(HOLD);
    sens_b[0] = 1'b0;
    cyc(12);
    check("mid_nopulse", en_n[0] - e0, 0);
    check("mid_occ_after", int'(occupancy), 0);

`ifdef PGC_DEBOUNCE_EN
    // short glitch must not move the gate FSM
    g0_busy = 1'b0;
    sens_a[0] = 1'b1;
    cyc(2);
    sens_a[0] = 1'b0;
    cyc(12);
    check("glitch_idle", int'(g0_busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parking_gate_counter.md
Name: parking_gate_counter

Overview:
Multi-gate parking lot occupancy counter. It generalises the single-lane entry/exit detector to NUM_GATES lanes, each with its own sensor-pair FSM. It adds a shared saturating occupancy counter with full/empty flags, sticky error flags and an occupancy load port. It sits between the raw gate sensors and the display/barrier logic.

Parameters:
NUM_GATES, 2, number of gate lanes, each with one sensor pair (a = outer, b = inner); range 1..8.
CAPACITY, 15, maximum lot occupancy; range 1..65535.
CNT_W, $clog2(CAPACITY+1), occupancy width; localparam, not overridable.
DEB_CYCLES, 4, debounce stability window in clk cycles; used only with PGC_DEBOUNCE_EN; range 1..255.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sens_a  in  NUM_GATES  outer sensor per gate, asynchronous to clk
sens_b  in  NUM_GATES  inner sensor per gate, asynchronous to clk
occ_load  in  1  synchronous load strobe for occupancy
occ_load_val  in  CNT_W  occupancy load value; values above CAPACITY are clamped to CAPACITY
err_clr  in  1  synchronous clear of the sticky error flags
car_enter  out  NUM_GATES  one-cycle pulse per gate: entry completed
car_exit  out  NUM_GATES  one-cycle pulse per gate: exit completed
occupancy  out  CNT_W  current car count
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0
ovf_err  out  1  sticky: an entry was attempted while full
unf_err  out  1  sticky: an exit was attempted while empty

Behaviour:
- Reset (async, reset_n low): all gate FSMs go to IDLE; synchronizer flops and debounce state go to 0. Outputs: car_enter=0, car_exit=0, occupancy=0, empty=1, full=0, ovf_err=0, unf_err=0.
- Input path: sens_a and sens_b each pass through a 2-flop synchronizer per bit. The FSM sees {a,b} 2 cycles after an input change, or later with debounce enabled.
- Per-gate FSM states: IDLE, EN1, EN2, EN3, EN_DONE, EX1, EX2, EX3, EX_DONE. Undefined encodings go to IDLE. Symbol is {a,b}.
  - IDLE: 10->EN1; 01->EX1; 00 or 11 stay.
  - EN1: 00->IDLE; 11->EN2; else hold.
  - EN2: 01->EN3; 10->EN1; else hold.
  - EN3: 00->EN_DONE; 11->EN2; else hold.
  - EN_DONE: ->IDLE unconditionally.
  - EX1: 00->IDLE; 11->EX2; else hold.
  - EX2: 10->EX3; 01->EX1; else hold.
  - EX3: 00->EX_DONE; 11->EX2; else hold.
  - EX_DONE: ->IDLE unconditionally.
- car_enter[i] is high exactly while gate i is in EN_DONE; car_exit[i] exactly while in EX_DONE. Each pulse lasts one cycle. A new sequence on the same gate cannot start until the cycle after the pulse.
- Occupancy update is registered. It takes effect in the cycle after the pulses.
  - E = popcount(car_enter), X = popcount(car_exit).
  - Compute nxt = occupancy + E - X signed, at width CNT_W+$clog2(NUM_GATES+1)+1.
  - nxt > CAPACITY: occupancy=CAPACITY, set ovf_err.
  - nxt < 0: occupancy=0, set unf_err.
  - Otherwise occupancy=nxt.
  - Simultaneous enter and exit on different gates net out with no error when the result is in range. Example: full lot, 1 enter + 1 exit leaves occupancy unchanged and ovf_err=0.
- occ_load has priority over the pulse update in the same cycle. Pulses in that cycle are discarded and do not set errors.
- err_clr clears both sticky flags. If an error condition occurs in the same cycle, set wins.
- full and empty are decoded from the occupancy register, with no extra latency.
- Reset mid-sequence: FSMs abort with no pulse; occupancy returns to 0.

Optional Feature:
Macro PGC_DEBOUNCE_EN.
- Defined: per gate, the synchronized {a,b} is forwarded to the FSM only after it has been stable for DEB_CYCLES consecutive cycles. A shorter glitch is ignored and the FSM keeps the last accepted value. Added latency is DEB_CYCLES cycles.
- Undefined: synchronized {a,b} feeds the FSM directly and DEB_CYCLES is unused.

Test Plan:
NUM_GATES=2, CAPACITY=3, feature off unless stated.
- Gate0 {a,b} sequence 00,10,11,01,00, each held 5 cycles -> one car_enter[0] pulse; occupancy 0->1 the next cycle; empty falls.
- Gate1 sequence 00,01,11,10,00 with occupancy=2 -> one car_exit[1] pulse; occupancy=1.
- Aborted entry on gate0 (00,10,11,10,00) -> no pulses; occupancy unchanged.
- occ_load with value 3 (full=1), then gate0 entry -> occupancy stays 3 and ovf_err=1. Then gate0 entry plus gate1 exit completing in the same cycle -> occupancy 3 and no new error. Then err_clr -> ovf_err=0.
- Gate1 exit with occupancy=0 -> occupancy 0, unf_err=1. Then reset_n low mid-sequence on gate0 -> all outputs at reset values, no pulse after release.
- PGC_DEBOUNCE_EN, DEB_CYCLES=4: 2-cycle glitch of 10 on gate0 -> FSM stays IDLE. Entry sequence held 6 cycles per step -> car_enter[0] arrives 4 cycles later than the feature-off run.
